// File: rtl/des_bus_master.sv
// -----------------------------------------------------------------------------
// des_bus_master
//   Initiator for the DES register bus. A host hands over one command at a
//   time on a valid/ready command channel. The module issues one single-cycle
//   DES request for it. For reads, it captures the responder's registered read
//   data RD_LATENCY cycles later. It then returns a response on a valid/ready
//   response channel and holds it until the host consumes it.
//
//   Optional feature (compile-time macro DES_WR_VERIFY_EN):
//     When defined, every write is followed by a read-back of the same
//     address, with one idle bus cycle in between. The response then carries
//     the read-back value, and rsp_err flags a mismatch against the written
//     data. When undefined, writes respond one cycle after the request and
//     rsp_err is tied to 0.
//
// Parameters
//   WIDTH       data width of Des_value / Des_rd_value / cmd_wdata / rsp_rdata
//   ADDR_W      DES address width
//   RD_LATENCY  cycles from the edge sampling Des_req_valid to the edge that
//               captures Des_rd_value (must be >= 1)
//
// Ports
//   clk           in   system clock, posedge
//   reset_n       in   asynchronous active-low reset
//   cmd_valid     in   command offered
//   cmd_ready     out  high only while idle; accept = cmd_valid & cmd_ready
//   cmd_wr_rd     in   1 = write, 0 = read
//   cmd_addr      in   register address
//   cmd_wdata     in   write data (ignored for reads)
//   Des_req_valid out  one-cycle DES transaction strobe
//   Des_wr_rd     out  DES direction, 1 = write (0 while strobe low)
//   Des_address   out  DES address (0 while strobe low)
//   Des_value     out  DES write data (0 for reads and while strobe low)
//   Des_rd_value  in   registered read data from the responder
//   rsp_valid     out  response available, held until rsp_ready
//   rsp_ready     in   response consumed on rsp_valid & rsp_ready
//   rsp_wr        out  response belongs to a write (1) or a read (0)
//   rsp_rdata     out  read data (0 for plain writes)
//   rsp_err       out  write-verify mismatch (0 without DES_WR_VERIFY_EN)
// -----------------------------------------------------------------------------
module des_bus_master #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_wdata,
  output logic              Des_req_valid,
  output logic              Des_wr_rd,
  output logic [ADDR_W-1:0] Des_address,
  output logic [WIDTH-1:0]  Des_value,
  input  logic [WIDTH-1:0]  Des_rd_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err
);

  // The wait counter counts down from RD_LATENCY-1; keep it at least 1 bit wide.
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
`ifdef DES_WR_VERIFY_EN
    , S_GAP,
    S_VREQ,
    S_VWAIT
`endif
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cmd_ready;
  logic               r_des_req_valid;
  logic               r_des_wr;
  logic [ADDR_W-1:0]  r_des_addr;
  logic [WIDTH-1:0]   r_des_value;
  logic               r_rsp_valid;
  logic               r_rsp_wr;
  logic [WIDTH-1:0]   r_rsp_rdata;
`ifdef DES_WR_VERIFY_EN
  logic               r_rsp_err;
  // The bus outputs are cleared after the write strobe, so the read-back
  // needs its own copy of the address and the data to compare against.
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic [WIDTH-1:0]   r_cmd_wdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_cmd_ready     <= 1'b0;
      r_des_req_valid <= 1'b0;
      r_des_wr        <= 1'b0;
      r_des_addr      <= '0;
      r_des_value     <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_wr        <= 1'b0;
      r_rsp_rdata     <= '0;
`ifdef DES_WR_VERIFY_EN
      r_rsp_err       <= 1'b0;
      r_cmd_addr      <= '0;
      r_cmd_wdata     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // cmd_ready is registered, so it rises on the first edge after
          // reset. A command can only be taken once it is visibly high.
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready     <= 1'b0;
            r_des_req_valid <= 1'b1;
            r_des_wr        <= cmd_wr_rd;
            r_des_addr      <= cmd_addr;
            r_des_value     <= cmd_wr_rd ? cmd_wdata : '0;
`ifdef DES_WR_VERIFY_EN
            r_cmd_addr      <= cmd_addr;
            r_cmd_wdata     <= cmd_wdata;
`endif
            r_state         <= S_REQ;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end

        S_REQ: begin
          // Strobe lasts exactly one cycle; bus fields return to zero with it.
          r_des_req_valid <= 1'b0;
          r_des_wr        <= 1'b0;
          r_des_addr      <= '0;
          r_des_value     <= '0;
          if (r_des_wr) begin
`ifdef DES_WR_VERIFY_EN
            r_state     <= S_GAP;
`else
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
`endif
          end else begin
            r_cnt   <= CNT_W'(RD_LATENCY - 1);
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= Des_rd_value;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

`ifdef DES_WR_VERIFY_EN
        S_GAP: begin
          // One idle bus cycle separates the write strobe from the read-back.
          r_des_req_valid <= 1'b1;
          r_des_wr        <= 1'b0;
          r_des_addr      <= r_cmd_addr;
          r_des_value     <= '0;
          r_state         <= S_VREQ;
        end

        S_VREQ: begin
          r_des_req_valid <= 1'b0;
          r_des_addr      <= '0;
          r_cnt           <= CNT_W'(RD_LATENCY - 1);
          r_state         <= S_VWAIT;
        end

        S_VWAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_wr    <= 1'b1;
            r_rsp_rdata <= Des_rd_value;
            r_rsp_err   <= (Des_rd_value != r_cmd_wdata);
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif

        S_RESP: begin
          // The response stays frozen until consumed. Going back to IDLE
          // re-opens the command channel on the same edge.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef DES_WR_VERIFY_EN
            r_rsp_err   <= 1'b0;
`endif
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign Des_req_valid = r_des_req_valid;
  assign Des_wr_rd     = r_des_wr;
  assign Des_address   = r_des_addr;
  assign Des_value     = r_des_value;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_wr        = r_rsp_wr;
  assign rsp_rdata     = r_rsp_rdata;
`ifdef DES_WR_VERIFY_EN
  assign rsp_err       = r_rsp_err;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_des_bus_master.sv
// -----------------------------------------------------------------------------
// tb_des_bus_master
//   Self-checking bench for des_bus_master. The bench contains a small DES
//   responder: registers at addresses 0..3, with unmapped addresses reading
//   as 0. The bench keeps its own register image to predict read data.
//   It drives directed and random commands, and it checks the following:
//     - request contents and count
//     - response latency, data and hold behaviour
//     - bus idle values
//     - reset behaviour
// -----------------------------------------------------------------------------
module tb_des_bus_master;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
  localparam int RDL    = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr_rd = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [WIDTH-1:0]  cmd_wdata = '0;
  logic              Des_req_valid;
  logic              Des_wr_rd;
  logic [ADDR_W-1:0] Des_address;
  logic [WIDTH-1:0]  Des_value;
  logic [WIDTH-1:0]  Des_rd_value;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_wr;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  val;
  } req_t;

  req_t       req_q[$];
  logic [7:0] model [0:7] = '{default: 8'h00};

  des_bus_master #(
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (RDL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_wr_rd     (cmd_wr_rd),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .Des_req_valid (Des_req_valid),
    .Des_wr_rd     (Des_wr_rd),
    .Des_address   (Des_address),
    .Des_value     (Des_value),
    .Des_rd_value  (Des_rd_value),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_wr        (rsp_wr),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Responder: registered read data one cycle after the request (RDL = 1).
  logic [7:0] resp_mem [0:3] = '{default: 8'h00};
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (Des_req_valid) begin
      if (Des_wr_rd) begin
        if (Des_address < 3'd4) resp_mem[Des_address[1:0]] <= Des_value;
        rd_q <= 8'h00;
      end else begin
        rd_q <= (Des_address < 3'd4) ? resp_mem[Des_address[1:0]] : 8'h00;
      end
    end else begin
      rd_q <= 8'h00;
    end
  end
  assign Des_rd_value = rd_q;

  // Bus monitor: log every request, check spacing and idle values.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_req <= 1'b0;
    end else begin
      if (Des_req_valid) begin
        req_q.push_back({Des_wr_rd, Des_address, Des_value});
        check("req_back_to_back", {31'd0, prev_req}, 32'd0);
      end else begin
        check("bus_idle_zero", {20'd0, Des_wr_rd, Des_address, Des_value}, 32'd0);
      end
      prev_req <= Des_req_valid;
    end
  end

  task automatic run_cmd(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                         input int hold);
    int n;
    int exp_lat;
    int exp_nreq;
    logic [7:0] exp_rd;
    logic exp_err;
    logic [7:0] held;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready !== 1'b1) return;
    req_q.delete();
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr_rd = 1'($urandom);
    cmd_addr  = 3'($urandom);
    cmd_wdata = 8'($urandom);
    check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);

    if (!wr) begin
      exp_rd   = (addr < 3'd4) ? model[addr] : 8'h00;
      exp_err  = 1'b0;
      exp_lat  = 1 + RDL;
      exp_nreq = 1;
    end else begin
`ifdef DES_WR_VERIFY_EN
      exp_rd   = (addr < 3'd4) ? data : 8'h00;
      exp_err  = (exp_rd != data);
      exp_lat  = 3 + RDL;
      exp_nreq = 2;
`else
      exp_rd   = 8'h00;
      exp_err  = 1'b0;
      exp_lat  = 1;
      exp_nreq = 1;
`endif
      if (addr < 3'd4) model[addr] = data;
    end

    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, exp_lat);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_wr", {31'd0, rsp_wr}, {31'd0, wr});
    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check("req_count", req_q.size(), exp_nreq);
    if (req_q.size() >= 1)
      check("req_first", {20'd0, req_q[0]}, {20'd0, wr, addr, (wr ? data : 8'h00)});
    if (exp_nreq == 2 && req_q.size() >= 2)
      check("req_readback", {20'd0, req_q[1]}, {20'd0, 1'b0, addr, 8'h00});

    // Host stalls the response; stray command offers must be ignored.
    held = rsp_rdata;
    repeat (hold) begin
      cmd_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, held});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    check("no_extra_req", req_q.size(), exp_nreq);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_req_valid", {31'd0, Des_req_valid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_bus", {20'd0, Des_wr_rd, Des_address, Des_value}, 32'd0);
    check("rst_rsp", {22'd0, rsp_wr, rsp_err, rsp_rdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("cmd_ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("cmd_ready_post_rst", {31'd0, cmd_ready}, 32'd1);

    // Directed cases
    run_cmd(1'b1, 3'd1, 8'h01, 0);
    run_cmd(1'b0, 3'd1, 8'hFF, 0);
    run_cmd(1'b0, 3'd5, 8'h00, 0);
    run_cmd(1'b0, 3'd1, 8'h00, 5);

    // Reset while waiting for read data
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr_rd = 1'b0;
    cmd_addr  = 3'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("wait_rst_req_valid", {31'd0, Des_req_valid}, 32'd0);
    check("wait_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("wait_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    req_q.delete();
    run_cmd(1'b1, 3'd2, 8'h3C, 0);
    run_cmd(1'b0, 3'd2, 8'h00, 1);

    // Reset while the write strobe is on the bus: the write must not land
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr_rd = 1'b1;
    cmd_addr  = 3'd3;
    cmd_wdata = 8'h77;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("req_rst_req_valid", {31'd0, Des_req_valid}, 32'd0);
    check("req_rst_bus", {20'd0, Des_wr_rd, Des_address, Des_value}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    req_q.delete();
    run_cmd(1'b0, 3'd3, 8'h00, 0);

    // Write-verify pair (plain writes without the feature)
    run_cmd(1'b1, 3'd2, 8'hA5, 0);
    run_cmd(1'b1, 3'd6, 8'h5A, 2);
    run_cmd(1'b0, 3'd2, 8'h00, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
              int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
